// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell iterated LSB-first,
// one bit per clock, under a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] wa;
  logic [WIDTH-1:0] wb;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nxt;
  logic [IDX_W-1:0] idx;
  logic             c;
  logic             c_nxt;
  logic             c_msb;
  logic             bit_s;
  logic             last;
  logic             accept;

  assign busy = (state == RUN);
  assign last = (idx == IDX_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single full-adder cell applied to the bit selected by idx
  always_comb begin
    bit_s         = wa[idx] ^ wb[idx] ^ c;
    c_nxt         = (wa[idx] & wb[idx]) | (wa[idx] & c) | (wb[idx] & c);
    work_nxt      = work;
    work_nxt[idx] = bit_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wa       <= '0;
      wb       <= '0;
      work     <= '0;
      idx      <= '0;
      c        <= 1'b0;
      c_msb    <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        wa    <= a;
        wb    <= sub ? ~b : b;
        c     <= sub ? ~cin : cin;
        idx   <= '0;
        work  <= '0;
        c_msb <= 1'b0;
      end else if (state == RUN) begin
        work <= work_nxt;
        c    <= c_nxt;
        idx  <= idx + IDX_W'(1);
        if (idx == IDX_W'(WIDTH - 2)) c_msb <= c_nxt;
        if (last) begin
          idx      <= '0;
          sum      <= work_nxt;
          cout     <= c_nxt;
          overflow <= c_msb ^ c_nxt;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed corners,
// handshake/reset cases and random ops against an arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_cmp = 0;
  int n_bad = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views
  function automatic logic [9:0] model(input logic [7:0] ia,
                                       input logic [7:0] ib,
                                       input logic icin,
                                       input logic isub);
    int ur;
    int sr;
    int sa;
    int sb;
    logic [7:0] s;
    logic co;
    logic ov;
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    if (isub) begin
      ur = int'(ia) - int'(ib) - int'(icin);
      sr = sa - sb - int'(icin);
      co = (ur >= 0);
    end else begin
      ur = int'(ia) + int'(ib) + int'(icin);
      sr = sa + sb + int'(icin);
      co = (ur > 255);
    end
    s  = 8'(ur & 255);
    ov = (sr > 127) || (sr < -128);
    return {ov, co, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; start is sampled at the next edge
  task automatic launch(input logic [7:0] ia, input logic [7:0] ib,
                        input logic icin, input logic isub);
    a     = ia;
    b     = ib;
    cin   = icin;
    sub   = isub;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    cin   = 1'($urandom);
    sub   = 1'($urandom);
  endtask

  // Waits for done; optionally injects a start at cycle inj of the run
  task automatic finish_op(input string tag, input logic [7:0] ia,
                           input logic [7:0] ib, input logic icin,
                           input logic isub, input int inj,
                           input bit full);
    logic [9:0] e;
    int n;
    int busy_cnt;
    e = model(ia, ib, icin, isub);
    n = 0;
    busy_cnt = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      if (n == inj) begin
        start = 1'b1;
        a     = 8'hA5;
        b     = 8'h5A;
      end
      tick();
      start = 1'b0;
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(e[7:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(e[8]));
    chk({tag, "_ovf"}, 32'(overflow), 32'(e[9]));
    if (full) begin
      chk({tag, "_lat"}, 32'(n), 32'd8);
      chk({tag, "_busycnt"}, 32'(busy_cnt), 32'd8);
      chk({tag, "_busy0"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic op(input string tag, input logic [7:0] ia,
                    input logic [7:0] ib, input logic icin,
                    input logic isub);
    launch(ia, ib, icin, isub);
    finish_op(tag, ia, ib, icin, isub, -1, 1'b0);
  endtask

  initial begin
    int ones;
    int dones;
    logic [7:0] held;
    logic [7:0] ra;
    logic [7:0] rb;
    logic rc;
    logic rs;

    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy || done) ones++;
    end
    chk("idle_quiet", 32'(ones), 32'd0);

    launch(8'h3C, 8'h0F, 1'b0, 1'b0);
    finish_op("add", 8'h3C, 8'h0F, 1'b0, 1'b0, -1, 1'b1);
    chk("add_exact", 32'(sum), 32'h4B);
    tick();
    chk("done_pulse1", 32'(done), 32'd0);

    op("add_ff", 8'hFF, 8'h01, 1'b1, 1'b0);
    chk("add_ff_exact", 32'(sum), 32'h01);
    op("add_7f", 8'h7F, 8'h01, 1'b0, 1'b0);
    chk("add_7f_ovf", 32'(overflow), 32'd1);

    op("sub_10", 8'h10, 8'h01, 1'b0, 1'b1);
    chk("sub_10_exact", 32'(sum), 32'h0F);
    op("sub_00", 8'h00, 8'h01, 1'b0, 1'b1);
    chk("sub_00_exact", 32'(sum), 32'hFF);
    op("sub_80", 8'h80, 8'h01, 1'b0, 1'b1);
    chk("sub_80_ovf", 32'(overflow), 32'd1);
    op("sub_05", 8'h05, 8'h02, 1'b1, 1'b1);
    chk("sub_05_exact", 32'(sum), 32'h02);

    launch(8'h21, 8'h13, 1'b0, 1'b0);
    finish_op("inj", 8'h21, 8'h13, 1'b0, 1'b0, 3, 1'b1);
    held  = sum;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) dones++;
    end
    chk("inj_no_second", 32'(dones), 32'd0);
    chk("hold_sum", 32'(sum), 32'(held));
    chk("hold_exact", 32'(sum), 32'h34);

    launch(8'h40, 8'h22, 1'b0, 1'b0);
    finish_op("b2b1", 8'h40, 8'h22, 1'b0, 1'b0, -1, 1'b1);
    launch(8'h90, 8'h35, 1'b1, 1'b1);
    chk("b2b_accept", 32'(busy), 32'd1);
    chk("b2b_sum_hold", 32'(sum), 32'h62);
    finish_op("b2b2", 8'h90, 8'h35, 1'b1, 1'b1, -1, 1'b0);

    launch(8'h55, 8'h66, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_sum", 32'(sum), 32'd0);
    chk("mid_cout", 32'(cout), 32'd0);
    chk("mid_ovf", 32'(overflow), 32'd0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) dones++;
    end
    chk("mid_no_done", 32'(dones), 32'd0);
    op("post_rst", 8'h01, 8'h01, 1'b0, 1'b0);
    chk("post_rst_exact", 32'(sum), 32'h02);

    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      launch(ra, rb, rc, rs);
      finish_op("rand", ra, rb, rc, rs, -1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
